datapath_controller: RTL and testbench
======================================

// Module: datapath_controller
// PURPOSE
//  Moore/Mealy FSM that sequences the general datapath (PC, IR, RAM, A register, add/sub unit).
//  Runs a fetch -> decode -> execute loop over 3-bit opcodes and drives every datapath control line.
//  It shares Clock and Reset with the datapath; the datapath's IR[7:5], Aeq0 and Apos feed back in.
// PARAMETERS
//  OPW      3  opcode width (IR[7:5])
//  STATE_W  4  state register width
// PORTS
//  Clock    in   1  system clock; all state changes on rising edge
//  Reset    in   1  synchronous, active-high; also resets the datapath
//  Enter    in   1  operator strobe, level-sampled only in INPUT state
//  IR       in   3  opcode from datapath instruction register
//  Aeq0     in   1  A == 0 flag from datapath
//  Apos     in   1  A > 0 flag from datapath
//  PCload   out  1  PC register update enable
//  JMPmux   out  1  1: PC <= IR[4:0]; 0: PC <= PC+1
//  IRload   out  1  IR <= RAM[addr]
//  Meminst  out  1  1: RAM address = IR[4:0]; 0: RAM address = PC
//  MemWr    out  1  RAM[addr] <= A
//  Aload    out  1  A register load enable
//  Sub      out  1  1: A - RAM; 0: A + RAM
//  Asel     out  2  A source: 0 = add/sub result, 1 = data_in, 2 = RAM data, 3 = unused
//  Halt     out  1  high while in HALT state
//  State    out  4  current state, for debug/LEDs
// BEHAVIOUR
//  Reset: synchronous, active-high; polarity and synchronicity fixed.
//  - A Reset on any edge forces State = START, including mid-instruction or during an INPUT wait.
//  - In START, every control output is 0 and Halt = 0.
//  States (encoding 0..10):
//  - START, FETCH, DECODE, LOAD, STORE, ADD, SUB, INPUT, JZ, JPOS, HALT.
//  Transitions:
//  - START -> FETCH, unconditional.
//  - FETCH -> DECODE.
//  - DECODE -> exec state chosen by IR: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INPUT, 101 JZ,
//    110 JPOS, 111 HALT.
//  - LOAD/STORE/ADD/SUB/JZ/JPOS -> FETCH.
//  - INPUT -> FETCH when Enter = 1; otherwise stays in INPUT.
//  - HALT stays in HALT until Reset.
//  Outputs: any output not listed for a state is 0.
//  - FETCH: Meminst=0, IRload=1, PCload=1, JMPmux=0. IR <= RAM[PC] and PC <= PC+1 on the same edge.
//  - DECODE: Meminst=1. Presents IR[4:0] to the RAM; no register writes.
//  - LOAD: Meminst=1, Asel=2, Aload=1.
//  - STORE: Meminst=1, MemWr=1.
//  - ADD: Meminst=1, Asel=0, Sub=0, Aload=1.
//  - SUB: Meminst=1, Asel=0, Sub=1, Aload=1.
//  - INPUT: Asel=1, Aload=Enter (Mealy).
//  - JZ: JMPmux=1, PCload=Aeq0 (Mealy).
//  - JPOS: JMPmux=1, PCload=Apos (Mealy).
//  - HALT: Halt=1.
//  Latency:
//  - 3 cycles per instruction.
//  - INPUT takes 3 + n cycles, where n = number of cycles Enter is low.
//  - Not-taken jumps also take 3 cycles.
//  Mealy outputs: the only combinational-from-input paths are Aload from Enter, and PCload from
//  Aeq0/Apos. All other outputs depend on State only.
//  Boundaries:
//  - PC wrap from 31 to 0 is the datapath's job; the controller is unaffected.
//  - Opcode 111 in DECODE always reaches HALT.
//  - Enter already high on INPUT entry completes INPUT in one cycle.
//  - MemWr and Aload are never high in the same cycle.
//  - IRload is high only in FETCH.
//  - Unused state codes 11..15 -> START on the next edge, with all outputs 0.
// STRUCTURE
//  Package datapath_ctrl_pkg:
//  - opcode localparams OP_LOAD..OP_HALT
//  - ASEL_ALU = 0, ASEL_IN = 1, ASEL_RAM = 2
//  - state encodings S_START..S_HALT
//  Implementation:
//  - single module: a state register, a next-state case block and an output case block
//  - no sub-module required
//  - top-level cpu_top instantiates datapath and datapath_controller
// TESTING
//  - Reset: Reset=1 for 2 clocks, release -> State START, then FETCH next edge with IRload=PCload=1.
//  - IR=010 after FETCH -> DECODE (Meminst=1) -> ADD: Aload=1, Asel=0, Sub=0 -> FETCH; 3 cycles total.
//  - IR=100, Enter low 4 cycles then high -> INPUT held 5 cycles, Aload=1 only on last -> FETCH.
//  - IR=101: Aeq0=0 -> PCload=0, JMPmux=1. Aeq0=1 -> PCload=1.
//  - IR=110: Apos=1 -> PCload=1, JMPmux=1; Apos=0 -> no load.
//  - IR=111 -> HALT, Halt=1 held 10 cycles.
//  - Reset asserted mid-INPUT or in HALT -> START next edge, all outputs 0.
//  - Program LOAD 5, ADD 5, STORE 6, HALT via the real datapath -> RAM[6] = 2*RAM[5], Halt=1.

Source files
------------

// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the general-datapath controller: opcodes, A-source selects,
// state encodings and the opcode-to-execute-state decode.
package datapath_ctrl_pkg;

    localparam int OPW     = 3;
    localparam int STATE_W = 4;

    localparam logic [OPW-1:0] OP_LOAD  = 3'b000;
    localparam logic [OPW-1:0] OP_STORE = 3'b001;
    localparam logic [OPW-1:0] OP_ADD   = 3'b010;
    localparam logic [OPW-1:0] OP_SUB   = 3'b011;
    localparam logic [OPW-1:0] OP_INPUT = 3'b100;
    localparam logic [OPW-1:0] OP_JZ    = 3'b101;
    localparam logic [OPW-1:0] OP_JPOS  = 3'b110;
    localparam logic [OPW-1:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ASEL_ALU = 2'd0;
    localparam logic [1:0] ASEL_IN  = 2'd1;
    localparam logic [1:0] ASEL_RAM = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_INPUT  = 4'd7,
        S_JZ     = 4'd8,
        S_JPOS   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    function automatic state_t exec_state(input logic [OPW-1:0] op);
        state_t s;
        s = S_HALT;
        case (op)
            OP_LOAD:  s = S_LOAD;
            OP_STORE: s = S_STORE;
            OP_ADD:   s = S_ADD;
            OP_SUB:   s = S_SUB;
            OP_INPUT: s = S_INPUT;
            OP_JZ:    s = S_JZ;
            OP_JPOS:  s = S_JPOS;
            default:  s = S_HALT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// Control/status bundle between the controller (master) and the datapath (slave).
interface datapath_ctrl_if;

    logic                                    Enter;
    logic [datapath_ctrl_pkg::OPW-1:0]       IR;
    logic                                    Aeq0;
    logic                                    Apos;
    logic                                    PCload;
    logic                                    JMPmux;
    logic                                    IRload;
    logic                                    Meminst;
    logic                                    MemWr;
    logic                                    Aload;
    logic                                    Sub;
    logic [1:0]                              Asel;
    logic                                    Halt;
    logic [datapath_ctrl_pkg::STATE_W-1:0]   State;

    modport master (
        input  Enter, IR, Aeq0, Apos,
        output PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
    );

    modport slave (
        output Enter, IR, Aeq0, Apos,
        input  PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
    );

endinterface

// File: rtl/datapath_controller.sv
// Fetch/decode/execute sequencer for the general datapath. Moore outputs except
// Aload in INPUT (from Enter) and PCload in JZ/JPOS (from Aeq0/Apos).
module datapath_controller
    import datapath_ctrl_pkg::*;
(
    input  logic           Clock,
    input  logic           Reset,
    datapath_ctrl_if.master bus
);

    state_t state;
    state_t state_nxt;

    logic       pc_load;
    logic       jmp_mux;
    logic       ir_load;
    logic       mem_inst;
    logic       mem_wr;
    logic       a_load;
    logic       sub;
    logic [1:0] a_sel;
    logic       halt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_START;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_START;
        case (state)
            S_START:  state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = exec_state(bus.IR);
            S_LOAD,
            S_STORE,
            S_ADD,
            S_SUB,
            S_JZ,
            S_JPOS:   state_nxt = S_FETCH;
            S_INPUT:  state_nxt = bus.Enter ? S_FETCH : S_INPUT;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_START;
        endcase
    end

    // In DECODE and the memory-operand states the RAM is addressed by IR[4:0].
    always_comb begin
        pc_load  = 1'b0;
        jmp_mux  = 1'b0;
        ir_load  = 1'b0;
        mem_inst = 1'b0;
        mem_wr   = 1'b0;
        a_load   = 1'b0;
        sub      = 1'b0;
        a_sel    = ASEL_ALU;
        halt     = 1'b0;
        case (state)
            S_FETCH: begin
                ir_load = 1'b1;
                pc_load = 1'b1;
            end
            S_DECODE: mem_inst = 1'b1;
            S_LOAD: begin
                mem_inst = 1'b1;
                a_sel    = ASEL_RAM;
                a_load   = 1'b1;
            end
            S_STORE: begin
                mem_inst = 1'b1;
                mem_wr   = 1'b1;
            end
            S_ADD: begin
                mem_inst = 1'b1;
                a_load   = 1'b1;
            end
            S_SUB: begin
                mem_inst = 1'b1;
                sub      = 1'b1;
                a_load   = 1'b1;
            end
            S_INPUT: begin
                a_sel  = ASEL_IN;
                a_load = bus.Enter;
            end
            S_JZ: begin
                jmp_mux = 1'b1;
                pc_load = bus.Aeq0;
            end
            S_JPOS: begin
                jmp_mux = 1'b1;
                pc_load = bus.Apos;
            end
            S_HALT:  halt = 1'b1;
            default: ;
        endcase
    end

    assign bus.PCload  = pc_load;
    assign bus.JMPmux  = jmp_mux;
    assign bus.IRload  = ir_load;
    assign bus.Meminst = mem_inst;
    assign bus.MemWr   = mem_wr;
    assign bus.Aload   = a_load;
    assign bus.Sub     = sub;
    assign bus.Asel    = a_sel;
    assign bus.Halt    = halt;
    assign bus.State   = state;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed + randomized bench for datapath_controller, with an instruction-level
// expectation model and a small behavioural datapath for the program run.
module tb_datapath_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    datapath_ctrl_if bus();

    datapath_controller dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    logic       use_dp   = 1'b0;
    logic       enter_drv = 1'b0;
    logic [2:0] ir_drv   = 3'd0;
    logic       aeq0_drv = 1'b0;
    logic       apos_drv = 1'b0;

    logic [4:0] pc;
    logic [7:0] ir;
    logic [7:0] a;
    logic [7:0] din = 8'h00;
    logic [7:0] ram      [32];
    logic [7:0] ram_init [32];
    logic [4:0] addr;

    assign addr      = bus.Meminst ? ir[4:0] : pc;
    assign bus.Enter = enter_drv;
    assign bus.IR    = use_dp ? ir[7:5] : ir_drv;
    assign bus.Aeq0  = use_dp ? (a == 8'd0) : aeq0_drv;
    assign bus.Apos  = use_dp ? ($signed(a) > 0) : apos_drv;

    // Behavioural datapath driven by the controller's control lines
    always @(posedge clk) begin
        if (rst) begin
            pc <= 5'd0;
            ir <= 8'd0;
            a  <= 8'd0;
            for (int k = 0; k < 32; k++) ram[k] <= ram_init[k];
        end else begin
            if (bus.IRload) ir <= ram[addr];
            if (bus.PCload) pc <= bus.JMPmux ? ir[4:0] : pc + 5'd1;
            if (bus.Aload) begin
                case (bus.Asel)
                    2'd0:    a <= bus.Sub ? a - ram[addr] : a + ram[addr];
                    2'd1:    a <= din;
                    default: a <= ram[addr];
                endcase
            end
            if (bus.MemWr) ram[addr] <= a;
        end
    end

    logic [9:0] obs;
    assign obs = {bus.PCload, bus.JMPmux, bus.IRload, bus.Meminst, bus.MemWr,
                  bus.Aload, bus.Sub, bus.Asel, bus.Halt};

    int total = 0;
    int bad   = 0;

    function automatic logic [9:0] mk(input logic pcl, input logic jm, input logic irl,
                                      input logic mi, input logic mw, input logic al,
                                      input logic sb, input logic [1:0] as, input logic h);
        return {pcl, jm, irl, mi, mw, al, sb, as, h};
    endfunction

    // Expected execute-cycle control word for an opcode, given the live inputs
    function automatic logic [9:0] exec_word(input int op, input logic en,
                                             input logic z, input logic p);
        logic [9:0] w;
        w = '0;
        case (op)
            0: w = mk(0, 0, 0, 1, 0, 1, 0, 2'd2, 0);
            1: w = mk(0, 0, 0, 1, 1, 0, 0, 2'd0, 0);
            2: w = mk(0, 0, 0, 1, 0, 1, 0, 2'd0, 0);
            3: w = mk(0, 0, 0, 1, 0, 1, 1, 2'd0, 0);
            4: w = mk(0, 0, 0, 0, 0, en, 0, 2'd1, 0);
            5: w = mk(z, 1, 0, 0, 0, 0, 0, 2'd0, 0);
            6: w = mk(p, 1, 0, 0, 0, 0, 0, 2'd0, 0);
            default: w = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 1);
        endcase
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_inputs();
        enter_drv = 1'($urandom);
        aeq0_drv  = 1'($urandom);
        apos_drv  = 1'($urandom);
    endtask

    task automatic check_cycle(input string tag, input int exp_state, input logic [9:0] exp_w);
        #1;
        chk({tag, "_state"}, 32'(bus.State), 32'(exp_state));
        chk({tag, "_ctrl"}, 32'(obs), 32'(exp_w));
        chk({tag, "_wr_ld_excl"}, 32'(bus.MemWr & bus.Aload), 32'd0);
    endtask

    // Entered at a FETCH cycle; leaves the bench at the first execute cycle
    task automatic to_exec(input int op);
        rand_inputs();
        ir_drv = 3'(op);
        check_cycle("fetch", 1, mk(1, 0, 1, 0, 0, 0, 0, 2'd0, 0));
        tick();
        rand_inputs();
        check_cycle("decode", 2, mk(0, 0, 0, 1, 0, 0, 0, 2'd0, 0));
        tick();
    endtask

    task automatic do_exec(input int op, input int n, input logic flag);
        if (op == 4) begin
            for (int i = 0; i < n; i++) begin
                enter_drv = 1'b0;
                check_cycle("input_wait", 7, exec_word(4, 1'b0, 1'b0, 1'b0));
                tick();
            end
            enter_drv = 1'b1;
            check_cycle("input_done", 7, exec_word(4, 1'b1, 1'b0, 1'b0));
            tick();
        end else if (op == 7) begin
            for (int i = 0; i < 10; i++) begin
                rand_inputs();
                check_cycle("halt", 10, exec_word(7, 1'b0, 1'b0, 1'b0));
                tick();
            end
        end else begin
            rand_inputs();
            if (op == 5) aeq0_drv = flag;
            if (op == 6) apos_drv = flag;
            check_cycle("exec", 3 + op, exec_word(op, enter_drv, aeq0_drv, apos_drv));
            tick();
        end
    endtask

    task automatic do_instr(input int op, input int n, input logic flag);
        to_exec(op);
        do_exec(op, n, flag);
    endtask

    initial begin
        logic [7:0] v;
        for (int k = 0; k < 32; k++) ram_init[k] = 8'h00;

        // Reset for two clocks with random inputs present
        rst = 1'b1;
        rand_inputs();
        ir_drv = 3'($urandom);
        tick();
        tick();
        check_cycle("reset", 0, 10'd0);
        rst = 1'b0;
        tick();

        // Directed instruction checks
        do_instr(2, 0, 1'b0);
        do_instr(4, 4, 1'b0);
        do_instr(4, 0, 1'b0);
        do_instr(5, 0, 1'b0);
        do_instr(5, 0, 1'b1);
        do_instr(6, 0, 1'b1);
        do_instr(6, 0, 1'b0);
        do_instr(0, 0, 1'b0);
        do_instr(1, 0, 1'b0);
        do_instr(3, 0, 1'b0);

        // Randomized instruction stream (no HALT so the loop keeps going)
        for (int i = 0; i < 40; i++) begin
            do_instr(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), 1'($urandom));
        end

        // Reset in the middle of an INPUT wait
        to_exec(4);
        enter_drv = 1'b0;
        check_cycle("midin_wait", 7, exec_word(4, 1'b0, 1'b0, 1'b0));
        tick();
        enter_drv = 1'b0;
        rst = 1'b1;
        check_cycle("midin_pre", 7, exec_word(4, 1'b0, 1'b0, 1'b0));
        tick();
        enter_drv = 1'b1;
        check_cycle("midin_reset", 0, 10'd0);
        rst = 1'b0;
        tick();

        // HALT holds, then reset leaves it
        do_instr(7, 0, 1'b0);
        rst = 1'b1;
        check_cycle("halt_pre", 10, exec_word(7, 1'b0, 1'b0, 1'b0));
        tick();
        check_cycle("halt_reset", 0, 10'd0);
        rst = 1'b0;
        tick();
        do_instr(2, 0, 1'b0);

        // Program LOAD 5, ADD 5, STORE 6, HALT through the behavioural datapath
        v = 8'($urandom);
        ram_init[0] = 8'h05;
        ram_init[1] = 8'h45;
        ram_init[2] = 8'h26;
        ram_init[3] = 8'hE0;
        ram_init[5] = v;
        ram_init[6] = 8'h00;
        use_dp    = 1'b1;
        enter_drv = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 60 && !bus.Halt; i++) tick();
        #1;
        chk("prog_halt", 32'(bus.Halt), 32'd1);
        chk("prog_state", 32'(bus.State), 32'd10);
        chk("prog_ram6", 32'(ram[6]), 32'((2 * int'(v)) % 256));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
